// File: rtl/jtag_seq_master.sv
// jtag_seq_master: JTAG TAP sequencer driving tck/tms/tdi and returning captured TDO bits.
// Executes one IR or DR scan per accepted command, replaying Test-Logic-Reset after every reset.
// Optional feature macro: JTAG_TDO_CAPTURE_EN (defined = TDO capture into rsp_data, undefined = rsp_data tied 0).
module jtag_seq_master #(
    parameter int unsigned DR_MAX   = 64,
    parameter int unsigned LEN_W    = 7,
    parameter int unsigned HALF_PER = 2,
    parameter int unsigned RST_TMS  = 5
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_ir,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DR_MAX-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DR_MAX-1:0] rsp_data,
    output logic              tck,
    output logic              tms,
    output logic              tdi,
    input  logic              tdo,
    output logic              busy
);

    localparam int unsigned HP_W = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
    localparam int unsigned RC_W = $clog2(RST_TMS);
    localparam logic [HP_W-1:0]  HP_LAST = HP_W'(HALF_PER - 1);
    localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RST_TMS - 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DR_MAX);

    typedef enum logic [3:0] {
        S_TLR, S_RTI, S_IDLE, S_SELDR, S_SELIR, S_CAPTURE, S_SHIFT, S_EXIT1, S_UPDATE
    } state_t;

    state_t             r_state;
    logic [HP_W-1:0]    r_hcnt;
    logic [RC_W-1:0]    r_rcnt;
    logic [LEN_W-1:0]   r_bit;
    logic [LEN_W-1:0]   r_len;
    logic [DR_MAX-1:0]  r_data;
    logic               r_ir;
    logic               r_scan;
    logic               r_tck;
    logic               r_tms;
    logic               r_tdi;
    logic               r_cmd_ready;
    logic               r_rsp_valid;

    logic               w_tick;
    logic               w_fall;
    logic               w_rise;
    logic               w_accept;
    logic               w_last;
    logic [LEN_W-1:0]   w_len_clamp;

    // Half-period tick, edge qualifiers and command acceptance.
    assign w_tick      = (r_state != S_IDLE) && (r_hcnt == HP_LAST);
    assign w_fall      = w_tick & r_tck;
    assign w_rise      = w_tick & ~r_tck;
    assign w_accept    = cmd_valid & r_cmd_ready;
    assign w_last      = (r_bit == (r_len - LEN_W'(1)));
    assign w_len_clamp = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;

    // TAP sequencer: one state per tck period, tms/tdi advance on the tck falling tick.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_state     <= S_TLR;
            r_hcnt      <= '0;
            r_rcnt      <= '0;
            r_bit       <= '0;
            r_len       <= '0;
            r_data      <= '0;
            r_ir        <= 1'b0;
            r_scan      <= 1'b0;
            r_tck       <= 1'b0;
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (r_state == S_IDLE || r_hcnt == HP_LAST) begin
                r_hcnt <= '0;
            end else begin
                r_hcnt <= r_hcnt + HP_W'(1);
            end
            if (w_tick) begin
                r_tck <= ~r_tck;
            end
            if (r_state == S_IDLE) begin
                if (w_accept) begin
                    r_state     <= S_SELDR;
                    r_tms       <= 1'b1;
                    r_tdi       <= 1'b0;
                    r_cmd_ready <= 1'b0;
                    r_scan      <= 1'b1;
                    r_ir        <= cmd_ir;
                    r_data      <= cmd_data;
                    r_len       <= w_len_clamp;
                    r_bit       <= '0;
                end
            end else if (w_fall) begin
                case (r_state)
                    S_TLR: begin
                        if (r_rcnt == RC_LAST) begin
                            r_state <= S_RTI;
                            r_tms   <= 1'b0;
                        end else begin
                            r_rcnt <= r_rcnt + RC_W'(1);
                        end
                    end
                    S_RTI: begin
                        r_state     <= S_IDLE;
                        r_tms       <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_rsp_valid <= r_scan;
                        r_scan      <= 1'b0;
                    end
                    S_SELDR: begin
                        if (r_ir) begin
                            r_state <= S_SELIR;
                            r_tms   <= 1'b1;
                        end else begin
                            r_state <= S_CAPTURE;
                            r_tms   <= (r_len == '0);
                        end
                    end
                    S_SELIR: begin
                        r_state <= S_CAPTURE;
                        r_tms   <= (r_len == '0);
                    end
                    S_CAPTURE: begin
                        if (r_len == '0) begin
                            r_state <= S_EXIT1;
                            r_tms   <= 1'b1;
                        end else begin
                            r_state <= S_SHIFT;
                            r_tdi   <= r_data[0];
                            r_data  <= r_data >> 1;
                            r_tms   <= (r_len == LEN_W'(1));
                            r_bit   <= '0;
                        end
                    end
                    S_SHIFT: begin
                        if (w_last) begin
                            r_state <= S_EXIT1;
                            r_tms   <= 1'b1;
                            r_tdi   <= 1'b0;
                        end else begin
                            r_bit  <= r_bit + LEN_W'(1);
                            r_tdi  <= r_data[0];
                            r_data <= r_data >> 1;
                            r_tms  <= ((r_bit + LEN_W'(2)) == r_len);
                        end
                    end
                    S_EXIT1: begin
                        r_state <= S_UPDATE;
                        r_tms   <= 1'b0;
                    end
                    S_UPDATE: begin
                        r_state <= S_RTI;
                        r_tms   <= 1'b0;
                    end
                    default: begin
                        r_state <= S_TLR;
                        r_tms   <= 1'b1;
                        r_rcnt  <= '0;
                    end
                endcase
            end
        end
    end

`ifdef JTAG_TDO_CAPTURE_EN
    logic [DR_MAX-1:0] r_rsp;

    // TDO capture on the tck rising tick of each SHIFT period; cleared on accept.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_rsp <= '0;
        end else if (r_state == S_IDLE && w_accept) begin
            r_rsp <= '0;
        end else if (w_rise && r_state == S_SHIFT) begin
            for (int k = 0; k < int'(DR_MAX); k++) begin
                if (LEN_W'(k) == r_bit) begin
                    r_rsp[k] <= tdo;
                end
            end
        end
    end

    assign rsp_data = r_rsp;
`else
    logic w_unused_tdo;

    assign w_unused_tdo = tdo;
    assign rsp_data     = '0;
`endif

    assign cmd_ready = r_cmd_ready;
    assign busy      = ~r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign tck       = r_tck;
    assign tms       = r_tms;
    assign tdi       = r_tdi;

endmodule

// File: tb/tb_jtag_seq_master.sv
// tb_jtag_seq_master: directed scans against jtag_seq_master with tdo looped back to tdi.
module tb_jtag_seq_master;

    localparam int unsigned DR_MAX = 64;
    localparam int unsigned LEN_W  = 7;
`ifdef JTAG_TDO_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic              w_clk = 1'b0;
    logic              w_rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_ir;
    logic [LEN_W-1:0]  cmd_len;
    logic [DR_MAX-1:0] cmd_data;
    logic              rsp_valid;
    logic [DR_MAX-1:0] rsp_data;
    logic              tck;
    logic              tms;
    logic              tdi;
    logic              tdo;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    // TAP edge log and response monitor
    logic              tms_log [0:1023];
    logic              tdi_log [0:1023];
    int                n_edge = 0;
    int                n_rsp  = 0;
    logic              prev_tck = 1'b0;
    logic [DR_MAX-1:0] rsp_seen = '0;

    assign tdo = tdi;

    jtag_seq_master #(
        .DR_MAX   (DR_MAX),
        .LEN_W    (LEN_W),
        .HALF_PER (1),
        .RST_TMS  (5)
    ) u_dut (
        .w_clk     (w_clk),
        .w_rst     (w_rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_ir    (cmd_ir),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .busy      (busy)
    );

    always #5 w_clk = ~w_clk;

    // Record tms/tdi at every tck rising edge and count rsp_valid pulses.
    always @(negedge w_clk) begin
        prev_tck <= tck;
        if (tck === 1'b1 && prev_tck === 1'b0) begin
            if (n_edge < 1024) begin
                tms_log[n_edge] <= tms;
                tdi_log[n_edge] <= tdi;
            end
            n_edge <= n_edge + 1;
        end
        if (rsp_valid === 1'b1) begin
            n_rsp    <= n_rsp + 1;
            rsp_seen <= rsp_data;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pack_log(input int base, input int cnt, input bit use_tdi);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < cnt && i < 128; i++) begin
            if (base + i < 1024) v[i] = use_tdi ? tdi_log[base + i] : tms_log[base + i];
        end
        return v;
    endfunction

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 2000; i++) begin
            @(negedge w_clk);
            if (cmd_ready === 1'b1) break;
        end
        check({tag, "_ready"}, 128'(cmd_ready), 128'(1));
    endtask

    task automatic run_scan(input string tag, input logic ir, input logic [LEN_W-1:0] len,
                            input logic [DR_MAX-1:0] data, input int exp_edges,
                            input logic [127:0] exp_tms, input logic [127:0] exp_tdi,
                            input logic [DR_MAX-1:0] exp_rsp, input bit poke_busy);
        int base_e;
        int base_r;
        wait_ready(tag);
        cmd_valid = 1'b1;
        cmd_ir    = ir;
        cmd_len   = len;
        cmd_data  = data;
        @(negedge w_clk);
        base_e    = n_edge;
        base_r    = n_rsp;
        cmd_valid = 1'b0;
        cmd_ir    = ~ir;
        cmd_data  = ~data;
        check({tag, "_busy"}, 128'(busy), 128'(1));
        check({tag, "_clr"}, 128'(rsp_data), 128'(0));
        if (poke_busy) begin
            repeat (20) @(negedge w_clk);
            cmd_valid = 1'b1;
            cmd_len   = 7'd3;
            for (int i = 0; i < 4; i++) begin
                @(negedge w_clk);
                check({tag, "_poke_ready"}, 128'(cmd_ready), 128'(0));
            end
            cmd_valid = 1'b0;
        end
        for (int i = 0; i < 2000; i++) begin
            @(negedge w_clk);
            if (n_rsp != base_r) break;
        end
        repeat (4) @(negedge w_clk);
        check({tag, "_rsp_cnt"}, 128'(n_rsp - base_r), 128'(1));
        check({tag, "_edges"}, 128'(n_edge - base_e), 128'(exp_edges));
        check({tag, "_tms"}, pack_log(base_e, n_edge - base_e, 1'b0), exp_tms);
        check({tag, "_tdi"}, pack_log(base_e, n_edge - base_e, 1'b1), exp_tdi);
        check({tag, "_rsp"}, 128'(rsp_seen), 128'(CAP ? exp_rsp : '0));
        check({tag, "_hold"}, 128'(rsp_data), 128'(CAP ? exp_rsp : '0));
        check({tag, "_idle"}, {126'b0, cmd_ready, tck}, 128'b10);
    endtask

    initial begin
        int base_e;
        int base_r;
        w_rst     = 1'b1;
        cmd_valid = 1'b0;
        cmd_ir    = 1'b0;
        cmd_len   = '0;
        cmd_data  = '0;
        repeat (3) @(negedge w_clk);
        check("rst_pins", {124'b0, tck, tms, tdi, rsp_valid}, 128'b0100);
        check("rst_ready", {126'b0, cmd_ready, busy}, 128'b01);
        check("rst_rsp", 128'(rsp_data), 128'(0));
        base_e = n_edge;
        w_rst  = 1'b0;
        wait_ready("tlr");
        repeat (2) @(negedge w_clk);
        check("tlr_edges", 128'(n_edge - base_e), 128'(6));
        check("tlr_tms", pack_log(base_e, n_edge - base_e, 1'b0), 128'h1F);
        check("tlr_tck", 128'(tck), 128'(0));
        check("tlr_no_rsp", 128'(n_rsp), 128'(0));

        // DR len=8: tms 1,0,0x7,1,1,0,0 ; tdi A5 LSB first on edges 2..9
        run_scan("dr8", 1'b0, 7'd8, 64'hDEAD_BEEF_0000_00A5, 13, 128'h601, 128'h294, 64'hA5, 1'b0);
        // IR len=4: tms 1,1,0,0,0,0,1,1,0,0 ; tdi 0,1,1,1 on edges 3..6
        run_scan("ir4", 1'b1, 7'd4, 64'h0000_0000_0000_000E, 10, 128'hC3, 128'h70, 64'hE, 1'b0);
        // len=0: tms 1,1,1,0,0, no shift
        run_scan("len0", 1'b0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5, 128'h7, 128'h0, 64'h0, 1'b0);
        // cmd_len=100 clamps to 64 shift periods; mid-scan cmd_valid ignored
        run_scan("len100", 1'b0, 7'd100, 64'h0123_4567_89AB_CDEF, 69,
                 128'h0000_0000_0000_0006_0000_0000_0000_0001,
                 {62'b0, 64'h0123_4567_89AB_CDEF, 2'b0}, 64'h0123_4567_89AB_CDEF, 1'b1);

        // Reset during SHIFT bit 3 of a DR len=8 scan
        wait_ready("abort");
        cmd_valid = 1'b1;
        cmd_ir    = 1'b0;
        cmd_len   = 7'd8;
        cmd_data  = 64'hA5;
        @(negedge w_clk);
        cmd_valid = 1'b0;
        base_e    = n_edge;
        base_r    = n_rsp;
        for (int i = 0; i < 200; i++) begin
            if (n_edge - base_e >= 5) break;
            @(negedge w_clk);
        end
        check("abort_reach", 128'(n_edge - base_e), 128'(5));
        w_rst = 1'b1;
        @(negedge w_clk);
        check("abort_pins", {125'b0, tck, tms, tdi}, 128'b010);
        check("abort_ready", {125'b0, cmd_ready, busy, rsp_valid}, 128'b010);
        check("abort_rsp", 128'(rsp_data), 128'(0));
        w_rst  = 1'b0;
        base_e = n_edge;
        wait_ready("abort_tlr");
        repeat (2) @(negedge w_clk);
        check("abort_tlr_edges", 128'(n_edge - base_e), 128'(6));
        check("abort_tlr_tms", pack_log(base_e, n_edge - base_e, 1'b0), 128'h1F);
        check("abort_no_rsp", 128'(n_rsp - base_r), 128'(0));

        // Normal operation after abort
        run_scan("dr3", 1'b0, 7'd3, 64'h6, 8, 128'h31, 128'h18, 64'h6, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
